gate_stim_checker: RTL and testbench

- Self-checking stimulus stage that sits directly upstream of a 2-input basic gate (AND_gate and its siblings) and drives its `a`/`b` inputs.
- Walks all four input vectors (00, 01, 10, 11), holds each for a programmable settle time, then samples the gate output `y` and compares it against a reference model.
- Reports an error count and a pass/fail flag, so basic-gate benches become automatic instead of waveform-inspected.

---
 rtl/dsd_gate_pkg.sv | 24 ++
 rtl/gate_ref_model.sv | 27 ++
 rtl/gate_stim_checker.sv | 95 +++++++++
 tb/tb_gate_stim_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dsd_gate_pkg.sv
// Shared definitions for the basic-gate stimulus checkers: gate opcodes,
// checker FSM states and the error counter width.
package dsd_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int ERR_W = 3;
  localparam logic [ERR_W-1:0] ERR_MAX = 3'd4;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for a 2-input basic gate; shared by the basic-gate
// checkers. Unknown opcodes yield 0.
module gate_ref_model
  import dsd_gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  // NOTE: assign a default before the case so no path leaves y_exp unassigned
  // and a latch can never be inferred.
  always_comb begin
    y_exp = 1'b0;
    case (op)
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_NAND: y_exp = ~(a & b);
      OP_NOR:  y_exp = ~(a | b);
      OP_XOR:  y_exp = a ^ b;
      OP_XNOR: y_exp = ~(a ^ b);
      default: y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Drives the four {a,b} vectors into a downstream 2-input gate, holds each for
// HOLD_CYCLES, samples y and counts mismatches against the reference model.
module gate_stim_checker
  import dsd_gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GATE_OP     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] OP        = 3'(GATE_OP);

  state_e           state;
  logic [3:0]       hold;
  logic             y_exp;
  logic [ERR_W-1:0] err_upd;

  gate_ref_model u_ref (
    .op    (OP),
    .a     (a),
    .b     (b),
    .y_exp (y_exp)
  );

  // Count after this cycle's comparison; saturates so it can never wrap.
  always_comb begin
    err_upd = err_count;
    if ((y != y_exp) && (err_count < ERR_MAX))
      err_upd = err_count + 1'b1;
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_idx   <= '0;
      hold      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_DRIVE;
            err_count <= '0;
            vec_idx   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            hold      <= HOLD_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (hold == '0) state <= ST_SAMPLE;
          else            hold  <= hold - 1'b1;
        end
        ST_SAMPLE: begin
          err_count <= err_upd;
          if (vec_idx == 2'd3) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_upd == '0);
          end else begin
            vec_idx <= vec_idx + 2'd1;
            {a, b}  <= vec_idx + 2'd1;
            hold    <= HOLD_LOAD;
            state   <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: three checker instances with different
// hold/opcode settings, each feeding a truth-table gate model.
module tb_gate_stim_checker;

  localparam int NDUT = 3;
  localparam int HOLD_TAB [NDUT] = '{4, 1, 3};
  localparam int OP_TAB   [NDUT] = '{0, 4, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [NDUT];
  logic [3:0] tt_v    [NDUT];
  logic       a_v     [NDUT];
  logic       b_v     [NDUT];
  logic       y_v     [NDUT];
  logic       busy_v  [NDUT];
  logic       done_v  [NDUT];
  logic       pass_v  [NDUT];
  logic [2:0] err_v   [NDUT];
  logic [1:0] vec_v   [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    // Downstream gate: bit {a,b} of the truth table, zero delay.
    assign y_v[g] = tt_v[g][{a_v[g], b_v[g]}];

    gate_stim_checker #(
      .HOLD_CYCLES (HOLD_TAB[g]),
      .GATE_OP     (OP_TAB[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .y         (y_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .pass      (pass_v[g]),
      .err_count (err_v[g]),
      .vec_idx   (vec_v[g])
    );
  end

  // Ideal truth table of each opcode, bit index = {a,b}.
  function automatic logic [3:0] ideal_tt(input int op);
    case (op)
      0:       return 4'b1000;
      1:       return 4'b1110;
      2:       return 4'b0111;
      3:       return 4'b0001;
      4:       return 4'b0110;
      5:       return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Checks edges n_first..n_last after the start edge (n=0 is the start edge
  // itself, already elapsed). Expected state derives from elapsed edge count.
  task automatic sweep_body(input string tag, input int k, input logic [3:0] miss,
                            input int n_first, input int n_last,
                            input bit keep, input int poke_at);
    int         h1, total, s, vec, e;
    logic [9:0] obs, exp;
    h1    = HOLD_TAB[k] + 1;
    total = 4 * h1;
    for (int n = n_first; n <= n_last; n++) begin
      if (n > n_first || n > 0) begin
        if (n > 0 && !(n == n_first && n_first > 0)) begin
          @(posedge clk); #1;
        end
      end
      s   = (n / h1 > 4) ? 4 : n / h1;
      vec = (s > 3) ? 3 : s;
      e   = 0;
      for (int j = 0; j < s; j++) e += int'(miss[j]);
      exp = {(n < total), (n >= total), (n >= total) && (e == 0),
             3'(e), 2'(vec), 2'(vec)};
      obs = {busy_v[k], done_v[k], pass_v[k], err_v[k], vec_v[k], a_v[k], b_v[k]};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s dut=%0d edge=%0d {busy,done,pass,err,vec,a,b} got=%b want=%b",
                 tag, k, n, obs, exp);
      end
      if (!keep) start_v[k] = (n == poke_at);
    end
  endtask

  // Pulses start (or holds it), then checks every edge until done. A negative
  // n_stop runs the full sweep; otherwise returns after edge n_stop.
  task automatic run_sweep(input string tag, input int k, input logic [3:0] gate_tt,
                           input bit keep, input int poke_at, input int n_stop);
    logic [3:0] miss;
    int         total;
    tt_v[k] = gate_tt;
    miss    = gate_tt ^ ideal_tt(OP_TAB[k]);
    total   = 4 * (HOLD_TAB[k] + 1);
    @(posedge clk); #1;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    sweep_body(tag, k, miss, 0, (n_stop < 0) ? total : n_stop, keep, poke_at);
    if (keep && n_stop < 0) begin
      // Start still high in DONE: the next edge must restart cleanly.
      @(posedge clk); #1;
      sweep_body({tag, "_restart"}, k, miss, 0, total, 1'b0, -1);
    end
    start_v[k] = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int k);
    logic [9:0] obs;
    obs = {busy_v[k], done_v[k], pass_v[k], err_v[k], vec_v[k], a_v[k], b_v[k]};
    vectors++;
    if (obs !== 10'b0) begin
      miscompares++;
      $display("FAIL %s dut=%0d outputs got=%b want=%b", tag, k, obs, 10'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      start_v[k] = 1'b1;
      tt_v[k]    = ideal_tt(OP_TAB[k]);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) check_idle("reset_with_start", k);
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) start_v[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) check_idle("idle_no_start", k);
  endtask

  task automatic test_and_correct();
    run_sweep("and_correct", 0, 4'b1000, 1'b0, -1, -1);
  endtask

  task automatic test_stuck_one();
    run_sweep("stuck_one", 0, 4'b1111, 1'b0, -1, -1);
  endtask

  task automatic test_or_vs_and();
    run_sweep("or_vs_and", 0, 4'b1110, 1'b0, -1, -1);
  endtask

  task automatic test_start_held();
    run_sweep("start_held", 0, 4'b1000, 1'b1, -1, -1);
  endtask

  task automatic test_rst_mid_sweep();
    // Stop during DRIVE of vector 2, then reset.
    run_sweep("rst_mid", 0, 4'b1000, 1'b0, -1, 2 * (HOLD_TAB[0] + 1) + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_mid_cleared", 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_mid_stays_idle", 0);
    run_sweep("rst_mid_fresh", 0, 4'b1000, 1'b0, -1, -1);
  endtask

  task automatic test_xor_hold1();
    run_sweep("xor_hold1", 1, 4'b0110, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    // Immediate restart from DONE, with a start poked mid-sweep that must be ignored.
    run_sweep("b2b_first", 2, 4'b0001, 1'b0, 5, -1);
    run_sweep("b2b_second", 2, 4'b1001, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    int         k, total, poke;
    logic [3:0] tt;
    for (int r = 0; r < 12; r++) begin
      k     = $urandom_range(0, NDUT - 1);
      tt    = 4'($urandom);
      total = 4 * (HOLD_TAB[k] + 1);
      poke  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, total - 2) : -1;
      run_sweep("random", k, tt, 1'b0, poke, -1);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      start_v[k] = 1'b0;
      tt_v[k]    = 4'b0000;
    end
    test_reset();
    test_and_correct();
    test_stuck_one();
    test_or_vs_and();
    test_start_held();
    test_rst_mid_sweep();
    test_xor_hold1();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
